// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the program-counter generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        RD_NONE = 3'd0,
        RD_EXC  = 3'd1,
        RD_ERET = 3'd2,
        RD_JR   = 3'd3,
        RD_JUMP = 3'd4,
        RD_BRCH = 3'd5,
        RD_SEQ  = 3'd6
    } redirect_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        is_misaligned = (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push at full overwrites the oldest entry.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         PCRst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] top,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] cnt_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        ptr_dec = (p == '0) ? PW'(DEPTH - 1) : p - PW'(1);
    endfunction

    assign top   = mem_r[ptr_dec(wr_ptr_r)];
    assign empty = (cnt_r == '0);

    // Stack storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Write pointer and occupancy count.
    always_ff @(posedge clk or posedge PCRst) begin
        if (PCRst) begin
            wr_ptr_r <= '0;
            cnt_r    <= '0;
        end else if (push) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
            cnt_r    <= (cnt_r == CW'(DEPTH)) ? cnt_r : cnt_r + CW'(1);
        end else if (pop && !empty) begin
            wr_ptr_r <= ptr_dec(wr_ptr_r);
            cnt_r    <= cnt_r - CW'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator with exception/EPC, stall, fetch handshake and HALT state.
// Optional return-address stack is enabled by defining RAS_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              OFF_W     = 16,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC),
    parameter int              RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             PCRst,
    input  logic             stall,
    input  logic             brch,
    input  logic [OFF_W-1:0] brch_off,
    input  logic             jump,
    input  logic [25:0]      jump_addr,
    input  logic             jr,
    input  logic [XLEN-1:0]  jr_target,
    input  logic             exc,
    input  logic             eret,
    input  logic             halt,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             fetch_valid,
    output logic [XLEN-1:0]  epc,
    output logic             addr_err,
    output logic             halted
`ifdef RAS_EN
    ,
    input  logic             link,
    input  logic             ras_pop,
    output logic             ras_empty
`endif
);
    pc_state_e       state_r;
    redirect_e       cause_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] epc_r;
    logic            fetch_valid_r;
    logic            addr_err_r;
    logic            halted_r;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] brch_tgt_s;
    logic [XLEN-1:0] jump_tgt_s;
    logic [XLEN-1:0] jr_sel_s;
    logic [XLEN-1:0] pc_next_s;
    logic            jr_mis_s;
    logic            save_epc_s;
    logic            redirect_s;

    assign pc_plus4_s = pc_r + XLEN'(4);
    assign brch_tgt_s = pc_plus4_s + {{(XLEN-OFF_W-2){brch_off[OFF_W-1]}}, brch_off, 2'b00};
    assign jump_tgt_s = {pc_plus4_s[XLEN-1:28], jump_addr, 2'b00};

`ifdef RAS_EN
    logic [XLEN-1:0] ras_top_s;
    logic            ras_empty_s;
    logic            ras_push_s;
    logic            ras_pop_s;

    // A same-cycle exception outranks JR/JUMP, so it blocks push and pop too.
    assign ras_push_s = (state_r == ST_RUN) && (cause_s == RD_JUMP) && link;
    assign ras_pop_s  = (state_r == ST_RUN) && (cause_s == RD_JR) && ras_pop && !ras_empty_s;
    assign jr_sel_s   = (ras_pop && !ras_empty_s) ? ras_top_s : jr_target;
    assign ras_empty  = ras_empty_s;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (XLEN)
    ) u_ras (
        .clk       (clk),
        .PCRst     (PCRst),
        .push      (ras_push_s),
        .push_data (pc_plus4_s),
        .pop       (ras_pop_s),
        .top       (ras_top_s),
        .empty     (ras_empty_s)
    );
`else
    logic unused_ras_s;
    assign unused_ras_s = (RAS_DEPTH != 0);
    assign jr_sel_s     = jr_target;
`endif

    assign jr_mis_s = is_misaligned(jr_sel_s[1:0]);

    // Priority encode the redirect cause; sequential advance needs the handshake.
    always_comb begin
        cause_s = RD_NONE;
        if (exc) begin
            cause_s = RD_EXC;
        end else if (eret) begin
            cause_s = RD_ERET;
        end else if (jr) begin
            cause_s = RD_JR;
        end else if (jump) begin
            cause_s = RD_JUMP;
        end else if (brch) begin
            cause_s = RD_BRCH;
        end else if (fetch_valid_r && fetch_ready && !stall) begin
            cause_s = RD_SEQ;
        end else begin
            cause_s = RD_NONE;
        end
    end

    // Next-PC mux and EPC-save decision for the winning cause.
    always_comb begin
        pc_next_s  = pc_r;
        save_epc_s = 1'b0;
        redirect_s = 1'b1;
        case (cause_s)
            RD_EXC: begin
                pc_next_s  = EXC_VEC;
                save_epc_s = 1'b1;
            end
            RD_ERET: pc_next_s = epc_r;
            RD_JR: begin
                pc_next_s  = jr_mis_s ? EXC_VEC : jr_sel_s;
                save_epc_s = jr_mis_s;
            end
            RD_JUMP: pc_next_s = jump_tgt_s;
            RD_BRCH: pc_next_s = brch_tgt_s;
            RD_SEQ: begin
                pc_next_s  = pc_plus4_s;
                redirect_s = 1'b0;
            end
            default: begin
                pc_next_s  = pc_r;
                redirect_s = 1'b0;
            end
        endcase
    end

    // FSM with registered pc, epc and status outputs.
    always_ff @(posedge clk or posedge PCRst) begin
        if (PCRst) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_VEC;
            epc_r         <= '0;
            fetch_valid_r <= 1'b0;
            addr_err_r    <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            addr_err_r <= 1'b0;
            case (state_r)
                ST_BOOT: begin
                    state_r       <= ST_RUN;
                    fetch_valid_r <= 1'b1;
                    halted_r      <= 1'b0;
                end
                ST_RUN: begin
                    if (halt && !redirect_s) begin
                        state_r       <= ST_HALT;
                        fetch_valid_r <= 1'b0;
                        halted_r      <= 1'b1;
                    end else begin
                        pc_r       <= pc_next_s;
                        addr_err_r <= (cause_s == RD_JR) && jr_mis_s;
                        if (save_epc_s) begin
                            epc_r <= pc_r;
                        end
                    end
                end
                ST_HALT: begin
                    if (exc) begin
                        state_r       <= ST_RUN;
                        pc_r          <= EXC_VEC;
                        epc_r         <= pc_r;
                        fetch_valid_r <= 1'b1;
                        halted_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_BOOT;
                    fetch_valid_r <= 1'b0;
                    halted_r      <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign fetch_valid = fetch_valid_r;
    assign epc         = epc_r;
    assign addr_err    = addr_err_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; RAS steps are built when RAS_EN is defined.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        PCRst;
    logic        stall;
    logic        brch;
    logic [15:0] brch_off;
    logic        jump;
    logic [25:0] jump_addr;
    logic        jr;
    logic [31:0] jr_target;
    logic        exc;
    logic        eret;
    logic        halt;
    logic        fetch_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic [31:0] epc;
    logic        addr_err;
    logic        halted;
`ifdef RAS_EN
    logic        link;
    logic        ras_pop;
    logic        ras_empty;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pc_gen dut (
        .clk         (clk),
        .PCRst       (PCRst),
        .stall       (stall),
        .brch        (brch),
        .brch_off    (brch_off),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .jr          (jr),
        .jr_target   (jr_target),
        .exc         (exc),
        .eret        (eret),
        .halt        (halt),
        .fetch_ready (fetch_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_valid (fetch_valid),
        .epc         (epc),
        .addr_err    (addr_err),
        .halted      (halted)
`ifdef RAS_EN
        ,
        .link        (link),
        .ras_pop     (ras_pop),
        .ras_empty   (ras_empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; brch = 1'b0; jump = 1'b0; jr = 1'b0;
        exc = 1'b0; eret = 1'b0; halt = 1'b0;
`ifdef RAS_EN
        link = 1'b0; ras_pop = 1'b0;
`endif
    endtask

    initial begin
        PCRst = 1'b1; fetch_ready = 1'b1;
        brch_off = 16'h0000; jump_addr = 26'h0; jr_target = 32'h0;
        idle();
        #12;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_epc", epc, 32'h0000_0000);
        chk1("rst_fv", fetch_valid, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_addr_err", addr_err, 1'b0);
        step();
        PCRst = 1'b0;
        chk("boot_pc", pc, 32'h0000_3000);
        step();
        chk("boot_edge_pc", pc, 32'h0000_3000);
        chk1("run_fv", fetch_valid, 1'b1);
        step();
        chk("seq1", pc, 32'h0000_3004);
        step();
        chk("seq2", pc, 32'h0000_3008);
        step(); step();
        chk("seq4", pc, 32'h0000_3010);

        brch = 1'b1; brch_off = 16'hFFFE;
        step();
        chk("brch_neg", pc, 32'h0000_300C);
        brch = 1'b0; fetch_ready = 1'b0;
        step();
        chk("nrdy_hold1", pc, 32'h0000_300C);
        chk1("nrdy_fv", fetch_valid, 1'b1);
        step();
        chk("nrdy_hold2", pc, 32'h0000_300C);
        fetch_ready = 1'b1; stall = 1'b1;
        step();
        chk("stall_hold", pc, 32'h0000_300C);
        stall = 1'b0;

        jr = 1'b1; jr_target = 32'h0000_3020;
        step();
        chk("jr_aligned", pc, 32'h0000_3020);
        jr = 1'b0; jump = 1'b1; jump_addr = 26'h0000C40;
        step();
        chk("jump", pc, 32'h0000_3100);
        jump = 1'b0; jr = 1'b1;
        step();
        jr = 1'b0; jump = 1'b1; stall = 1'b1;
        step();
        chk("jump_stall", pc, 32'h0000_3100);
        idle();

        jr = 1'b1; jr_target = 32'h0000_3050;
        step();
        jr = 1'b0; exc = 1'b1; jump = 1'b1;
        step();
        chk("exc_jump_pc", pc, 32'h0000_4180);
        chk("exc_jump_epc", epc, 32'h0000_3050);
        idle(); eret = 1'b1;
        step();
        chk("eret_pc", pc, 32'h0000_3050);
        idle(); jr = 1'b1; jr_target = 32'h0000_3054;
        step();
        idle(); exc = 1'b1; eret = 1'b1;
        step();
        chk("exc_eret_pc", pc, 32'h0000_4180);
        chk("exc_eret_epc", epc, 32'h0000_3054);

        idle(); jr = 1'b1; jr_target = 32'h0000_3060;
        step();
        jr_target = 32'h0000_3002;
        step();
        chk("jr_mis_pc", pc, 32'h0000_4180);
        chk("jr_mis_epc", epc, 32'h0000_3060);
        chk1("addr_err_set", addr_err, 1'b1);
        idle(); fetch_ready = 1'b0;
        step();
        chk1("addr_err_clr", addr_err, 1'b0);
        chk("addr_err_hold", pc, 32'h0000_4180);
        fetch_ready = 1'b1;

        jr = 1'b1; jr_target = 32'h0000_3070;
        step();
        chk("pc_plus4", pc_plus4, 32'h0000_3074);
        idle(); halt = 1'b1; brch = 1'b1; brch_off = 16'h0004;
        step();
        chk("halt_brch_pc", pc, 32'h0000_3084);
        chk1("halt_brch_halted", halted, 1'b0);
        idle(); jr = 1'b1;
        step();
        idle(); halt = 1'b1;
        step();
        chk1("halt_halted", halted, 1'b1);
        chk1("halt_fv", fetch_valid, 1'b0);
        chk("halt_pc", pc, 32'h0000_3070);
        halt = 1'b0; brch = 1'b1; jump = 1'b1; jr = 1'b1; eret = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("halt_frozen", pc, 32'h0000_3070);
            chk1("halt_stays", halted, 1'b1);
        end
        idle(); exc = 1'b1;
        step();
        chk("halt_exc_pc", pc, 32'h0000_4180);
        chk1("halt_exc_halted", halted, 1'b0);
        chk1("halt_exc_fv", fetch_valid, 1'b1);

        idle(); jump = 1'b1;
        #2 PCRst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h0000_3000);
        chk1("async_rst_fv", fetch_valid, 1'b0);
        step();
        idle(); PCRst = 1'b0;
        step();
        chk("rst2_boot_pc", pc, 32'h0000_3000);

`ifdef RAS_EN
        chk1("ras_empty_rst", ras_empty, 1'b1);
        jump = 1'b1; link = 1'b1; jump_addr = 26'h0000C40;
        step();
        chk("ras_jump_pc", pc, 32'h0000_3100);
        chk1("ras_not_empty", ras_empty, 1'b0);
        idle(); jr = 1'b1; ras_pop = 1'b1; jr_target = 32'h0000_5000;
        step();
        chk("ras_pop_pc", pc, 32'h0000_3004);
        chk1("ras_empty_pop", ras_empty, 1'b1);
        step();
        chk("ras_pop_empty_pc", pc, 32'h0000_5000);
        idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
